// File: rtl/rv_pkg.sv
// Shared register-bank types for the issue path: default widths, address/data
// typedefs and the packed issue-field bundle.
package rv_pkg;

  localparam int REG_AWIDTH = 3;
  localparam int REG_DWIDTH = 8;

  typedef logic [REG_AWIDTH-1:0] reg_addr_t;
  typedef logic [REG_DWIDTH-1:0] reg_data_t;

  typedef struct packed {
    reg_addr_t rs1;
    reg_addr_t rs2;
    reg_addr_t rd;
    logic      rd_wen;
  } issue_t;

endpackage

// File: rtl/operand_fetch_if.sv
// Decode-to-fetch and fetch-to-execute handshakes of operand_fetch.
// The master side drives instructions in and consumes the operand slot.
interface operand_fetch_if #(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [AWIDTH-1:0] in_rs1;
  logic [AWIDTH-1:0] in_rs2;
  logic [AWIDTH-1:0] in_rd;
  logic              in_rd_wen;
  logic              out_valid;
  logic              out_ready;
  logic [DWIDTH-1:0] out_op1;
  logic [DWIDTH-1:0] out_op2;
  logic [AWIDTH-1:0] out_rd;
  logic              out_rd_wen;

  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_rd_wen, out_ready,
    input  in_ready, out_valid, out_op1, out_op2, out_rd, out_rd_wen
  );

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, in_rd_wen, out_ready,
    output in_ready, out_valid, out_op1, out_op2, out_rd, out_rd_wen
  );
endinterface

// File: rtl/operand_fetch_scoreboard.sv
// Per-register busy bits for outstanding writes; register 0 is never busy.
// Flush beats everything, and a set beats a clear of the same bit.
module operand_fetch_scoreboard #(
  parameter int AWIDTH = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_en,
  input  logic [AWIDTH-1:0] set_addr,
  input  logic              clr_en,
  input  logic [AWIDTH-1:0] clr_addr,
  input  logic              flush,
  input  logic [AWIDTH-1:0] look_rs1,
  input  logic [AWIDTH-1:0] look_rs2,
  input  logic [AWIDTH-1:0] look_rd,
  output logic              busy_rs1,
  output logic              busy_rs2,
  output logic              busy_rd
);
  localparam int NREG = 1 << AWIDTH;

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_next;

  always_comb begin
    busy_next = busy;
    if (clr_en) busy_next[clr_addr] = 1'b0;
    if (set_en) busy_next[set_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else if (flush) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  assign busy_rs1 = busy[look_rs1];
  assign busy_rs2 = busy[look_rs2];
  assign busy_rd  = busy[look_rd];
endmodule

// File: rtl/operand_fetch.sv
// Issue-side operand reader with busy scoreboard and a one-entry output slot.
// Define OPFETCH_BYPASS_EN to forward same-cycle write-back data to sources.
module operand_fetch
  import rv_pkg::*;
#(
  parameter int AWIDTH = REG_AWIDTH,
  parameter int DWIDTH = REG_DWIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  operand_fetch_if.slave    bus,
  output logic [AWIDTH-1:0] raddr1,
  output logic [AWIDTH-1:0] raddr2,
  input  logic [DWIDTH-1:0] rdata1,
  input  logic [DWIDTH-1:0] rdata2,
  input  logic              wb_valid,
  input  logic [AWIDTH-1:0] wb_addr,
  input  logic [DWIDTH-1:0] wb_data,
  input  logic              flush
);
  localparam logic [AWIDTH-1:0] ZERO_ADDR = '0;

  logic busy_rs1, busy_rs2, busy_rd;
  logic fwd1, fwd2;
  logic hazard;
  logic accept;
  logic [DWIDTH-1:0] op1_sel, op2_sel;

  function automatic logic [DWIDTH-1:0] src_operand(
    input logic [AWIDTH-1:0] addr,
    input logic              fwd,
    input logic [DWIDTH-1:0] fwd_data,
    input logic [DWIDTH-1:0] bank_data
  );
    if (addr == ZERO_ADDR) return '0;
    else if (fwd)          return fwd_data;
    else                   return bank_data;
  endfunction

  assign raddr1 = bus.in_rs1;
  assign raddr2 = bus.in_rs2;

  operand_fetch_scoreboard #(.AWIDTH(AWIDTH)) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (accept && bus.in_rd_wen && (bus.in_rd != ZERO_ADDR)),
    .set_addr (bus.in_rd),
    .clr_en   (wb_valid && (wb_addr != ZERO_ADDR)),
    .clr_addr (wb_addr),
    .flush    (flush),
    .look_rs1 (bus.in_rs1),
    .look_rs2 (bus.in_rs2),
    .look_rd  (bus.in_rd),
    .busy_rs1 (busy_rs1),
    .busy_rs2 (busy_rs2),
    .busy_rd  (busy_rd)
  );

`ifdef OPFETCH_BYPASS_EN
  assign fwd1 = wb_valid && (wb_addr == bus.in_rs1) && (bus.in_rs1 != ZERO_ADDR);
  assign fwd2 = wb_valid && (wb_addr == bus.in_rs2) && (bus.in_rs2 != ZERO_ADDR);
`else
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif

  // A forwarded source is satisfied this cycle; the WAW check never forwards.
  assign hazard = (busy_rs1 && (bus.in_rs1 != ZERO_ADDR) && !fwd1)
               || (busy_rs2 && (bus.in_rs2 != ZERO_ADDR) && !fwd2)
               || (bus.in_rd_wen && busy_rd && (bus.in_rd != ZERO_ADDR));

  assign bus.in_ready = !hazard && !flush && (!bus.out_valid || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  assign op1_sel = src_operand(bus.in_rs1, fwd1, wb_data, rdata1);
  assign op2_sel = src_operand(bus.in_rs2, fwd2, wb_data, rdata2);

  // Output slot: accept -> slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid  <= 1'b0;
      bus.out_op1    <= '0;
      bus.out_op2    <= '0;
      bus.out_rd     <= '0;
      bus.out_rd_wen <= 1'b0;
    end else if (flush) begin
      bus.out_valid <= 1'b0;
    end else if (accept) begin
      bus.out_valid  <= 1'b1;
      bus.out_op1    <= op1_sel;
      bus.out_op2    <= op2_sel;
      bus.out_rd     <= bus.in_rd;
      bus.out_rd_wen <= bus.in_rd_wen;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: bank model, scoreboard queue of expected
// slot contents, immediate assertions at every comparison.
module tb_operand_fetch;
  import rv_pkg::*;

  typedef struct packed {
    reg_data_t op1;
    reg_data_t op2;
    reg_addr_t rd;
    logic      rd_wen;
  } exp_t;

  logic      clk = 1'b0;
  logic      rst_n = 1'b0;
  reg_addr_t raddr1, raddr2;
  reg_data_t rdata1, rdata2;
  logic      wb_valid = 1'b0;
  reg_addr_t wb_addr = '0;
  reg_data_t wb_data = '0;
  logic      flush = 1'b0;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  // Bank register 0 deliberately reads non-zero so operand zero-forcing shows.
  reg_data_t bank [8];

  operand_fetch_if #(.AWIDTH(REG_AWIDTH), .DWIDTH(REG_DWIDTH)) bus ();

  operand_fetch #(.AWIDTH(REG_AWIDTH), .DWIDTH(REG_DWIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .raddr1   (raddr1),
    .raddr2   (raddr2),
    .rdata1   (rdata1),
    .rdata2   (rdata2),
    .wb_valid (wb_valid),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .flush    (flush)
  );

  always #5 clk = ~clk;

  assign rdata1 = bank[raddr1];
  assign rdata2 = bank[raddr2];

  always @(posedge clk) begin
    if (!rst_n) begin
      bank[0] <= 8'hEE; bank[1] <= 8'h01; bank[2] <= 8'h11; bank[3] <= 8'h22;
      bank[4] <= 8'h04; bank[5] <= 8'h05; bank[6] <= 8'h06; bank[7] <= 8'h07;
    end else if (wb_valid && wb_addr != 3'd0) begin
      bank[wb_addr] <= wb_data;
    end
  end

  function automatic reg_data_t model_op(reg_addr_t a);
    if (a == 3'd0) return '0;
`ifdef OPFETCH_BYPASS_EN
    if (wb_valid && wb_addr == a) return wb_data;
`endif
    return bank[a];
  endfunction

  // Slot scoreboard: pop on consume, push on accept.
  always @(negedge clk) begin
    if (!rst_n || flush) begin
      exp_q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        exp_t e;
        exp_t o;
        o = {bus.out_op1, bus.out_op2, bus.out_rd, bus.out_rd_wen};
        checks++;
        if (exp_q.size() == 0) begin
          assert (1'b0) else begin
            errors++;
            $error("FAIL slot_unexpected: observed %h expected none", o);
          end
        end else begin
          e = exp_q.pop_front();
          assert (o === e) else begin
            errors++;
            $error("FAIL slot_data: observed %h expected %h", o, e);
          end
        end
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back({model_op(bus.in_rs1), model_op(bus.in_rs2), bus.in_rd, bus.in_rd_wen});
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic issue(input reg_addr_t rs1, input reg_addr_t rs2, input reg_addr_t rd, input logic wen);
    issue_t f;
    f = '{rs1: rs1, rs2: rs2, rd: rd, rd_wen: wen};
    bus.in_valid  = 1'b1;
    bus.in_rs1    = f.rs1;
    bus.in_rs2    = f.rs2;
    bus.in_rd     = f.rd;
    bus.in_rd_wen = f.rd_wen;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.in_rd     = '0;
    bus.in_rd_wen = 1'b0;
    bus.out_ready = 1'b1;

    // Reset
    repeat (2) @(posedge clk);
    sample();
    chk("rst_out_valid", bus.out_valid, 0);
    tick(); rst_n = 1'b1;
    sample();
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_op1", bus.out_op1, 0);
    chk("rst_out_rd_wen", bus.out_rd_wen, 0);

    // Basic read
    tick(); issue(3'd2, 3'd3, 3'd0, 1'b0);
    sample();
    chk("rd_raddr1", raddr1, 2);
    chk("rd_raddr2", raddr2, 3);
    chk("rd_in_ready", bus.in_ready, 1);
    tick(); idle();
    sample();
    chk("rd_out_valid", bus.out_valid, 1);
    chk("rd_op1", bus.out_op1, 8'h11);
    chk("rd_op2", bus.out_op2, 8'h22);
    tick();
    sample();
    chk("drain_out_valid", bus.out_valid, 0);

    // RAW on r4 (source 0 reads as zero)
    tick(); issue(3'd0, 3'd0, 3'd4, 1'b1);
    sample();
    tick(); issue(3'd4, 3'd1, 3'd5, 1'b0);
    sample();
    chk("raw_stall", bus.in_ready, 0);
    chk("zero_src_op1", bus.out_op1, 0);
    tick(); wb_valid = 1'b1; wb_addr = 3'd4; wb_data = 8'h5A;
    sample();
`ifdef OPFETCH_BYPASS_EN
    chk("raw_wb_cycle_ready", bus.in_ready, 1);
    tick(); wb_valid = 1'b0; idle();
    sample();
    chk("byp_out_valid", bus.out_valid, 1);
    chk("byp_op1", bus.out_op1, 8'h5A);
`else
    chk("raw_wb_cycle_ready", bus.in_ready, 0);
    tick(); wb_valid = 1'b0;
    sample();
    chk("raw_after_wb_ready", bus.in_ready, 1);
    tick(); idle();
    sample();
    chk("raw_out_valid", bus.out_valid, 1);
    chk("raw_op1", bus.out_op1, 8'h5A);
`endif

    // WAW on r6, write-back of r6 in the stalled cycle is not forwarded to rd
    tick(); issue(3'd0, 3'd0, 3'd6, 1'b1);
    sample();
    tick(); issue(3'd1, 3'd1, 3'd6, 1'b1); wb_valid = 1'b1; wb_addr = 3'd6; wb_data = 8'h66;
    sample();
    chk("waw_stall", bus.in_ready, 0);
    tick(); wb_valid = 1'b0;
    sample();
    chk("waw_release", bus.in_ready, 1);

    // Set and clear of r7 in the same cycle: set wins
    tick(); issue(3'd0, 3'd0, 3'd7, 1'b1); wb_valid = 1'b1; wb_addr = 3'd7; wb_data = 8'h33;
    sample();
    chk("setclr_ready", bus.in_ready, 1);
    tick(); wb_valid = 1'b0; issue(3'd7, 3'd0, 3'd0, 1'b0);
    sample();
    chk("set_wins", bus.in_ready, 0);

    // Flush with in_valid and write-back active
    tick(); flush = 1'b1; wb_valid = 1'b1; wb_addr = 3'd3; wb_data = 8'h44;
    sample();
    chk("flush_in_ready", bus.in_ready, 0);
    tick(); flush = 1'b0; wb_valid = 1'b0; issue(3'd6, 3'd7, 3'd6, 1'b1);
    sample();
    chk("flush_out_valid", bus.out_valid, 0);
    chk("flush_busy_clr", bus.in_ready, 1);
    tick(); idle();
    sample();

    // Back-pressure holds the slot
    tick(); bus.out_ready = 1'b0; issue(3'd2, 3'd0, 3'd0, 1'b0);
    sample();
    chk("bp_first_ready", bus.in_ready, 1);
    tick(); issue(3'd3, 3'd0, 3'd0, 1'b0);
    sample();
    chk("bp_in_ready", bus.in_ready, 0);
    chk("bp_out_valid", bus.out_valid, 1);
    chk("bp_hold_op1_a", bus.out_op1, 8'h11);
    tick();
    sample();
    chk("bp_hold_op1_b", bus.out_op1, 8'h11);
    chk("bp_hold_op2", bus.out_op2, 0);
    tick(); bus.out_ready = 1'b1;
    sample();
    chk("bp_release", bus.in_ready, 1);

    // Back-to-back issue, one accept per cycle
    for (int i = 0; i < 4; i++) begin
      tick(); issue(3'(i + 1), 3'(i + 2), 3'd0, 1'b0);
      sample();
      chk("b2b_ready", bus.in_ready, 1);
      chk("b2b_out_valid", bus.out_valid, 1);
    end

    // rd = 0 with write enable never sets a busy bit
    tick(); issue(3'd0, 3'd0, 3'd0, 1'b1);
    sample();
    tick(); issue(3'd0, 3'd0, 3'd0, 1'b1);
    sample();
    chk("rd0_nostall", bus.in_ready, 1);
    tick(); issue(3'd0, 3'd2, 3'd0, 1'b0);
    sample();
    chk("rd0_src_nostall", bus.in_ready, 1);

    // Mid-stream reset
    tick(); bus.out_ready = 1'b0; issue(3'd0, 3'd0, 3'd3, 1'b1);
    sample();
    tick(); idle();
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_out_rd_wen", bus.out_rd_wen, 0);
    sample();
    tick(); rst_n = 1'b1; bus.out_ready = 1'b1; issue(3'd3, 3'd3, 3'd3, 1'b1);
    sample();
    chk("mid_rst_busy_clr", bus.in_ready, 1);
    tick(); idle();
    sample();
    tick();
    sample();
    chk("final_out_valid", bus.out_valid, 0);
    chk("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
